// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and constants for the memory port arbiter. These are the
//   arbiter FSM state codes, the request owner codes and the Sram MemWrite
//   encoding (IDLE/BYTE/HALF/WORD). The package also provides a helper that
//   gives the access footprint in bytes.
//   Optional feature macro used by the files that import this package:
//   MEM_ARB_ALIGN_CHECK_EN.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  localparam logic [1:0] WRITE_IDLE = 2'd0;
  localparam logic [1:0] WRITE_BYTE = 2'd1;
  localparam logic [1:0] WRITE_HALF = 2'd2;
  localparam logic [1:0] WRITE_WORD = 2'd3;

  // Bytes touched by an access. Any read covers a full word, so a read that is
  // combined with a narrow write is still sized and aligned as a word.
  function automatic logic [2:0] access_size(input logic rd, input logic [1:0] wr);
    if (rd || wr == WRITE_WORD) return 3'd4;
    else if (wr == WRITE_HALF)  return 3'd2;
    else if (wr == WRITE_BYTE)  return 3'd1;
    else                        return 3'd0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_align.sv
// mem_align_check
//   Combinational alignment and range check for one Sram access.
//   Ports:
//     mem_read  in  1   access reads a word
//     mem_write in  2   WRITE_IDLE/BYTE/HALF/WORD
//     addr      in  32  byte address
//     err       out 1   misaligned, or the access runs past MEM_BYTES
//   The top instantiates this module only when MEM_ARB_ALIGN_CHECK_EN is defined.
module mem_align_check
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        mem_read,
  input  logic [1:0]  mem_write,
  input  logic [31:0] addr,
  output logic        err
);

  logic [2:0]  size;
  logic [32:0] end_addr;

  always_comb begin
    size     = access_size(mem_read, mem_write);
    end_addr = {1'b0, addr} + {30'd0, size};
    err      = 1'b0;
    if (size == 3'd4 && addr[1:0] != 2'b00) err = 1'b1;
    if (size == 3'd2 && addr[0])            err = 1'b1;
    // The address is widened to 33 bits so that wrap at 2^32 is still caught.
    if (size != 3'd0 && end_addr > 33'(MEM_BYTES)) err = 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, byte-addressed Sram between the instruction
//   fetch port (I) and the load/store port (D). Each request takes three
//   cycles: it is accepted in IDLE, drives the Sram in ACCESS, and returns a
//   one-cycle response in RESP.
//   Parameters:
//     FIXED_PRIO  0 = round-robin on ties; 1 = D always wins ties
//     MEM_BYTES   Sram size, used only by the optional range check
//   Ports:
//     clk, rst (async, active-high)
//     I port: i_req_valid/i_req_ready, i_addr, i_resp_valid, i_rdata
//     D port: d_req_valid/d_req_ready, d_mem_read, d_mem_write, d_addr, d_wdata,
//             d_resp_valid, d_rdata, d_resp_err
//     Sram:   mem_read, mem_write, mem_addr, mem_wdata, mem_rdata
//   Optional feature: MEM_ARB_ALIGN_CHECK_EN. When it is defined, misaligned or
//   out-of-range requests are suppressed at the Sram and answered with rdata=0.
//   D requests also report err=1.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int          FIXED_PRIO = 0,
  parameter int unsigned MEM_BYTES  = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_addr,
  output logic        i_resp_valid,
  output logic [31:0] i_rdata,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_mem_read,
  input  logic [1:0]  d_mem_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_resp_valid,
  output logic [31:0] d_rdata,
  output logic        d_resp_err,
  output logic        mem_read,
  output logic [1:0]  mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  arb_state_t  state, state_nxt;
  owner_t      last_grant, owner;
  logic        req_read, req_err;
  logic [1:0]  req_write;
  logic [31:0] req_addr, req_wdata, cap_data;

  logic        sel_read, sel_err;
  logic [1:0]  sel_write;
  logic [31:0] sel_addr, sel_wdata;

  // The winner's request fields. A fetch is always a plain word read.
  assign sel_read  = d_req_ready ? d_mem_read  : 1'b1;
  assign sel_write = d_req_ready ? d_mem_write : WRITE_IDLE;
  assign sel_addr  = d_req_ready ? d_addr      : i_addr;
  assign sel_wdata = d_req_ready ? d_wdata     : 32'd0;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  mem_align_check #(.MEM_BYTES(MEM_BYTES)) u_align (
    .mem_read  (sel_read),
    .mem_write (sel_write),
    .addr      (sel_addr),
    .err       (sel_err)
  );
`else
  // MEM_BYTES matters only to the range check, which is not built here.
  logic [31:0] unused_mem_bytes;
  assign unused_mem_bytes = 32'(MEM_BYTES);
  assign sel_err          = 1'b0;
`endif

  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    i_req_ready  = 1'b0;
    d_req_ready  = 1'b0;
    mem_read     = 1'b0;
    mem_write    = WRITE_IDLE;
    i_resp_valid = 1'b0;
    d_resp_valid = 1'b0;
    i_rdata      = 32'd0;
    d_rdata      = 32'd0;
    d_resp_err   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (!rst) begin
          if (i_req_valid && d_req_valid) begin
            // On a tie the port that was not granted last wins, unless D is pinned.
            if (FIXED_PRIO != 0 || last_grant == OWNER_I) d_req_ready = 1'b1;
            else                                          i_req_ready = 1'b1;
          end else begin
            i_req_ready = i_req_valid;
            d_req_ready = d_req_valid;
          end
        end
        if (i_req_ready || d_req_ready) state_nxt = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        // A flagged request still occupies this slot, but the Sram stays idle.
        mem_read  = req_read && !req_err;
        mem_write = req_err ? WRITE_IDLE : req_write;
        state_nxt = ARB_RESP;
      end
      ARB_RESP: begin
        if (owner == OWNER_I) begin
          i_resp_valid = 1'b1;
          i_rdata      = cap_data;
        end else begin
          d_resp_valid = 1'b1;
          d_rdata      = cap_data;
          d_resp_err   = req_err;
        end
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= OWNER_D;
      owner      <= OWNER_I;
      req_read   <= 1'b0;
      req_write  <= WRITE_IDLE;
      req_addr   <= 32'd0;
      req_wdata  <= 32'd0;
      req_err    <= 1'b0;
      cap_data   <= 32'd0;
    end else begin
      if (i_req_ready || d_req_ready) begin
        owner      <= d_req_ready ? OWNER_D : OWNER_I;
        last_grant <= d_req_ready ? OWNER_D : OWNER_I;
        req_read   <= sel_read;
        req_write  <= sel_write;
        req_addr   <= sel_addr;
        req_wdata  <= sel_wdata;
        req_err    <= sel_err;
      end
      // The Sram read is combinational, so the word is captured at the end of
      // ACCESS. This returns the pre-write contents for a read+write.
      if (state == ARB_ACCESS) cap_data <= mem_read ? mem_rdata : 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Bench for mem_port_arbiter. It uses a behavioural Sram, directed
//   transactions and random two-port traffic. A transaction-level reference
//   model predicts readiness, the Sram port, and the responses.
//   A second instance with FIXED_PRIO=1 exercises the D-always-wins mode.
//   Honours MEM_ARB_ALIGN_CHECK_EN in its expectations.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam logic [1:0] W_IDLE = 2'd0, W_BYTE = 2'd1, W_HALF = 2'd2, W_WORD = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0, i_req_ready;
  logic [31:0] i_addr = '0;
  logic        i_resp_valid;
  logic [31:0] i_rdata;
  logic        d_req_valid = 1'b0, d_req_ready;
  logic        d_mem_read = 1'b0;
  logic [1:0]  d_mem_write = W_IDLE;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_resp_valid, d_resp_err;
  logic [31:0] d_rdata;
  logic        mem_read;
  logic [1:0]  mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.FIXED_PRIO(0), .MEM_BYTES(65536)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_resp_valid(i_resp_valid), .i_rdata(i_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_mem_read(d_mem_read),
    .d_mem_write(d_mem_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_resp_valid(d_resp_valid), .d_rdata(d_rdata), .d_resp_err(d_resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Fixed-priority instance: both ports request continuously, and D does no-ops.
  logic        f_i_valid = 1'b0, f_i_ready, f_i_resp_valid;
  logic [31:0] f_i_rdata;
  logic        f_d_valid = 1'b0, f_d_ready, f_d_resp_valid, f_d_resp_err;
  logic [31:0] f_d_rdata;
  logic        f_mem_read;
  logic [1:0]  f_mem_write;
  logic [31:0] f_mem_addr, f_mem_wdata;
  logic [31:0] f_mem_rdata = 32'd0;

  mem_port_arbiter #(.FIXED_PRIO(1), .MEM_BYTES(65536)) dut_fp (
    .clk(clk), .rst(rst),
    .i_req_valid(f_i_valid), .i_req_ready(f_i_ready), .i_addr(32'h0000_0040),
    .i_resp_valid(f_i_resp_valid), .i_rdata(f_i_rdata),
    .d_req_valid(f_d_valid), .d_req_ready(f_d_ready), .d_mem_read(1'b0),
    .d_mem_write(W_IDLE), .d_addr(32'h0000_0080), .d_wdata(32'd0),
    .d_resp_valid(f_d_resp_valid), .d_rdata(f_d_rdata), .d_resp_err(f_d_resp_err),
    .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata)
  );

  int nvec = 0, nbad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pattern(input int a);
    return 8'(a * 7 + 3);
  endfunction

  function automatic logic [15:0] ix(input logic [31:0] a, input int k);
    return 16'(a + 32'(k));
  endfunction

  function automatic int wsize(input logic [1:0] wr);
    return (wr == W_WORD) ? 4 : (wr == W_HALF) ? 2 : (wr == W_BYTE) ? 1 : 0;
  endfunction

  // Sram behaviour: combinational read and a write at the clock edge.
  logic [7:0] sram [0:65535];
  assign mem_rdata = mem_read ? {sram[ix(mem_addr,3)], sram[ix(mem_addr,2)],
                                 sram[ix(mem_addr,1)], sram[ix(mem_addr,0)]} : 32'h0BAD_F00D;
  initial begin
    for (int a = 0; a < 65536; a++) sram[a] = (a < 256) ? pattern(a) : 8'h00;
    sram[16'h10] = 8'hEF; sram[16'h11] = 8'hBE; sram[16'h12] = 8'hAD; sram[16'h13] = 8'hDE;
    forever begin
      @(posedge clk);
      for (int k = 0; k < wsize(mem_write); k++) sram[ix(mem_addr,k)] <= mem_wdata[8*k +: 8];
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    bit          own_d;
    bit          rd;
    logic [1:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
  } txn_t;

  logic [7:0] ref_mem [0:65535];

  function automatic bit model_err(input bit rd, input logic [1:0] wr, input logic [31:0] a);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    int s;
    s = rd ? 4 : wsize(wr);
    if (s == 0) return 1'b0;
    if (s == 4 && (a % 4) != 0) return 1'b1;
    if (s == 2 && (a % 2) != 0) return 1'b1;
    if (longint'(a) + longint'(s) > 65536) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    txn_t cur;
    bit   busy, last_d, exp_ir, exp_dr, exp_mr, exp_iv, exp_dv;
    int   ph;
    logic [1:0] exp_mw;
    for (int a = 0; a < 65536; a++) ref_mem[a] = (a < 256) ? pattern(a) : 8'h00;
    ref_mem[16'h10] = 8'hEF; ref_mem[16'h11] = 8'hBE; ref_mem[16'h12] = 8'hAD; ref_mem[16'h13] = 8'hDE;
    busy = 0; last_d = 1; ph = 0;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      if (rst) begin
        chk_eq("rst_i_ready", i_req_ready, 0);
        chk_eq("rst_d_ready", d_req_ready, 0);
        chk_eq("rst_i_resp", i_resp_valid, 0);
        chk_eq("rst_d_resp", d_resp_valid, 0);
        chk_eq("rst_d_err", d_resp_err, 0);
        chk_eq("rst_i_rdata", i_rdata, 0);
        chk_eq("rst_d_rdata", d_rdata, 0);
        chk_eq("rst_mem_read", mem_read, 0);
        chk_eq("rst_mem_write", mem_write, W_IDLE);
        chk_eq("rst_mem_addr", mem_addr, 0);
        chk_eq("rst_mem_wdata", mem_wdata, 0);
        busy = 0; last_d = 1;
        continue;
      end
      exp_ir = !busy && i_req_valid && (!d_req_valid || last_d);
      exp_dr = !busy && d_req_valid && (!i_req_valid || !last_d);
      chk_eq("i_ready", i_req_ready, exp_ir);
      chk_eq("d_ready", d_req_ready, exp_dr);
      exp_mr = busy && ph == 1 && cur.rd && !cur.err;
      exp_mw = (busy && ph == 1 && !cur.err) ? cur.wr : W_IDLE;
      chk_eq("mem_read", mem_read, exp_mr);
      chk_eq("mem_write", mem_write, exp_mw);
      if (busy && ph == 1) begin
        if (exp_mr || exp_mw != W_IDLE) chk_eq("mem_addr", mem_addr, cur.addr);
        if (exp_mw != W_IDLE) chk_eq("mem_wdata", mem_wdata, cur.wdata);
        cur.rdata = exp_mr ? {ref_mem[ix(cur.addr,3)], ref_mem[ix(cur.addr,2)],
                              ref_mem[ix(cur.addr,1)], ref_mem[ix(cur.addr,0)]} : 32'd0;
        for (int k = 0; k < wsize(exp_mw); k++) ref_mem[ix(cur.addr,k)] = cur.wdata[8*k +: 8];
      end
      exp_iv = busy && ph == 2 && !cur.own_d;
      exp_dv = busy && ph == 2 && cur.own_d;
      chk_eq("i_resp_valid", i_resp_valid, exp_iv);
      chk_eq("d_resp_valid", d_resp_valid, exp_dv);
      if (exp_iv) chk_eq("i_rdata", i_rdata, cur.rdata);
      if (exp_dv) begin
        chk_eq("d_rdata", d_rdata, cur.rdata);
        chk_eq("d_resp_err", d_resp_err, cur.err);
      end
      if (busy) begin
        if (ph == 2) busy = 0;
        else         ph = 2;
      end else if (exp_dr) begin
        cur = '{own_d: 1, rd: d_mem_read, wr: d_mem_write, addr: d_addr, wdata: d_wdata,
                err: model_err(d_mem_read, d_mem_write, d_addr), rdata: 0};
        busy = 1; ph = 1; last_d = 1;
      end else if (exp_ir) begin
        cur = '{own_d: 0, rd: 1, wr: W_IDLE, addr: i_addr, wdata: 0,
                err: model_err(1, W_IDLE, i_addr), rdata: 0};
        busy = 1; ph = 1; last_d = 0;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic issue_i(input logic [31:0] a);
    int n;
    i_addr = a; i_req_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!i_req_ready && n < 50) begin n++; @(negedge clk); end
    if (!i_req_ready) chk_eq("i_timeout", i_req_ready, 1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic issue_d(input bit rd, input logic [1:0] wr, input logic [31:0] a, input logic [31:0] wd);
    int n;
    d_mem_read = rd; d_mem_write = wr; d_addr = a; d_wdata = wd; d_req_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!d_req_ready && n < 50) begin n++; @(negedge clk); end
    if (!d_req_ready) chk_eq("d_timeout", d_req_ready, 1);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 32'hFFFC + 32'($urandom_range(0, 3));
    return 32'($urandom_range(0, 255));
  endfunction

  // Fixed-priority instance: I must never be granted while D keeps requesting.
  initial begin
    int grants;
    grants = 0;
    @(negedge rst);
    @(posedge clk); #1;
    f_i_valid = 1'b1; f_d_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk_eq("fp_i_ready", f_i_ready, 0);
      chk_eq("fp_mem_write", f_mem_write, W_IDLE);
      if (f_d_ready) grants++;
    end
    chk_eq("fp_d_grants", grants, 4);
    @(posedge clk); #1;
    f_i_valid = 1'b0; f_d_valid = 1'b0;
  end

  initial begin
    int nbytes;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    gap(1);

    // Fetch of a preloaded word, with explicit latency checks.
    issue_i(32'h10);
    @(negedge clk);
    chk_eq("t1_mem_read", mem_read, 1);
    chk_eq("t1_mem_addr", mem_addr, 32'h10);
    @(negedge clk);
    chk_eq("t1_i_resp", i_resp_valid, 1);
    chk_eq("t1_i_rdata", i_rdata, 32'hDEADBEEF);
    gap(1);

    // Store word, then load it back.
    issue_d(0, W_WORD, 32'h20, 32'h11223344);
    gap(2);
    issue_d(1, W_IDLE, 32'h20, 32'h0);
    gap(2);
    chk_eq("m20", sram[16'h20], 8'h44);
    chk_eq("m21", sram[16'h21], 8'h33);
    chk_eq("m22", sram[16'h22], 8'h22);
    chk_eq("m23", sram[16'h23], 8'h11);

    // Byte store, half store at an odd address, no-op, and read+write.
    issue_d(0, W_BYTE, 32'h31, 32'h000000AB);
    gap(2);
    chk_eq("m31", sram[16'h31], 8'hAB);
    issue_d(0, W_HALF, 32'h41, 32'h0000BEEF);
    gap(2);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    chk_eq("m41", sram[16'h41], pattern(32'h41));
`else
    chk_eq("m41", sram[16'h41], 8'hEF);
    chk_eq("m42", sram[16'h42], 8'hBE);
`endif
    issue_d(0, W_IDLE, 32'h60, 32'hFFFFFFFF);
    gap(2);
    issue_d(1, W_WORD, 32'h20, 32'hCAFEF00D);
    gap(2);

    // Reset during the ACCESS cycle of a word store drops it silently.
    issue_d(0, W_WORD, 32'h50, 32'h55667788);
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    gap(3);
    chk_eq("rst_m50", sram[16'h50], pattern(32'h50));

    // Both ports valid back to back: grants must alternate.
    fork
      begin for (int k = 0; k < 6; k++) issue_i(32'(4 * k)); end
      begin for (int k = 0; k < 6; k++) issue_d(1, W_IDLE, 32'(8 * k), 32'h0); end
    join
    gap(3);

    // Random two-port traffic.
    fork
      begin
        for (int k = 0; k < 80; k++) begin
          gap($urandom_range(0, 2));
          issue_i(rand_addr());
        end
      end
      begin
        for (int k = 0; k < 80; k++) begin
          int kind;
          gap($urandom_range(0, 2));
          kind = $urandom_range(0, 5);
          case (kind)
            0: issue_d(0, W_IDLE, rand_addr(), $urandom);
            1: issue_d(1, W_IDLE, rand_addr(), $urandom);
            2: issue_d(0, W_BYTE, rand_addr(), $urandom);
            3: issue_d(0, W_HALF, rand_addr(), $urandom);
            4: issue_d(0, W_WORD, rand_addr(), $urandom);
            default: issue_d(1, 2'($urandom_range(1, 3)), rand_addr(), $urandom);
          endcase
        end
      end
    join
    gap(4);

    nbytes = 0;
    for (int a = 0; a < 65536; a++) if (sram[a] !== ref_mem[a]) nbytes++;
    chk_eq("mem_image_diffs", nbytes, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
